// File: rtl/breathing_pwm_multi.sv
// Multi-channel breathing PWM: each channel emits n high ticks then LOW_MULT*n low ticks,
// with n stepping along a triangle or sawtooth. Define BREATH_PRESCALE_EN for a shared tick prescaler.
module breathing_pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int N_MAX    = 15,
  parameter int LOW_MULT = 2,
  parameter int PRESCALE = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS-1:0]                 en,
  input  logic [CHANNELS-1:0]                 mode,
  output logic [CHANNELS-1:0]                 pwm_out,
  output logic [CHANNELS-1:0]                 period_done,
  output logic [CHANNELS*$clog2(N_MAX+1)-1:0] level
);

  localparam int N_W   = $clog2(N_MAX + 1);
  localparam int CNT_W = $clog2(LOW_MULT * N_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Elaboration-time guard: illegal parameter sets produce a visibly named empty block.
  if (CHANNELS < 1 || N_MAX < 1 || LOW_MULT < 1 || PRESCALE < 1) begin : g_illegal_params
  end

  logic tick;

`ifdef BREATH_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] ps_cnt;

  // Free-running, independent of any channel enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_W'(PRESCALE - 1)) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));
`else
  assign tick = 1'b1;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N_W-1:0]   n;
    logic             dir_up;
    logic             pwm_q;
    logic             pd_q;

    logic [N_W-1:0]   n_next;
    logic             dir_up_next;
    logic [CNT_W-1:0] high_last;
    logic [CNT_W-1:0] low_last;

    always_comb begin
      high_last   = CNT_W'(n) - CNT_W'(1);
      low_last    = CNT_W'(LOW_MULT) * CNT_W'(n) - CNT_W'(1);
      n_next      = n;
      dir_up_next = 1'b1;
      if (N_MAX == 1) begin
        n_next = N_W'(1);
      end else if (mode[c]) begin
        // Sawtooth keeps dir up, so a later switch to triangle always starts climbing.
        n_next = (n == N_W'(N_MAX)) ? N_W'(1) : n + N_W'(1);
      end else if (dir_up) begin
        if (n == N_W'(N_MAX)) begin
          n_next      = N_W'(N_MAX - 1);
          dir_up_next = 1'b0;
        end else begin
          n_next = n + N_W'(1);
        end
      end else begin
        if (n == N_W'(1)) begin
          n_next = N_W'(2);
        end else begin
          n_next      = n - N_W'(1);
          dir_up_next = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        n      <= N_W'(1);
        dir_up <= 1'b1;
        pwm_q  <= 1'b0;
        pd_q   <= 1'b0;
      end else begin
        pd_q <= 1'b0;
        if (!en[c]) begin
          state  <= ST_IDLE;
          cnt    <= '0;
          n      <= N_W'(1);
          dir_up <= 1'b1;
          pwm_q  <= 1'b0;
        end else if (tick) begin
          case (state)
            ST_IDLE: begin
              state <= ST_HIGH;
              cnt   <= '0;
              pwm_q <= 1'b1;
            end
            ST_HIGH: begin
              if (cnt == high_last) begin
                state <= ST_LOW;
                cnt   <= '0;
                pwm_q <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            ST_LOW: begin
              if (cnt == low_last) begin
                state  <= ST_HIGH;
                cnt    <= '0;
                pwm_q  <= 1'b1;
                pd_q   <= 1'b1;
                n      <= n_next;
                dir_up <= dir_up_next;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            default: begin
              state <= ST_IDLE;
              cnt   <= '0;
              pwm_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign pwm_out[c]            = pwm_q;
    assign period_done[c]        = pd_q;
    assign level[c*N_W +: N_W]   = n;
  end

endmodule

// File: tb/tb_breathing_pwm_multi.sv
// Directed bench for breathing_pwm_multi: default build, triangle/sawtooth at N_MAX=3, and N_MAX=1.
module tb_breathing_pwm_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default parameters: 4 channels, N_MAX=15, LOW_MULT=2
  logic [3:0]  d_en, d_mode, d_pwm, d_pd;
  logic [15:0] d_level;
  // 2 channels, N_MAX=3, LOW_MULT=1
  logic [1:0]  t_en, t_mode, t_pwm, t_pd;
  logic [3:0]  t_level;
  // 1 channel, N_MAX=1, LOW_MULT=1
  logic        o_en, o_mode, o_pwm, o_pd;
  logic [0:0]  o_level;

  breathing_pwm_multi u_def (
    .clk(clk), .rst(rst), .en(d_en), .mode(d_mode),
    .pwm_out(d_pwm), .period_done(d_pd), .level(d_level)
  );

  breathing_pwm_multi #(.CHANNELS(2), .N_MAX(3), .LOW_MULT(1)) u_tri (
    .clk(clk), .rst(rst), .en(t_en), .mode(t_mode),
    .pwm_out(t_pwm), .period_done(t_pd), .level(t_level)
  );

  breathing_pwm_multi #(.CHANNELS(1), .N_MAX(1), .LOW_MULT(1)) u_one (
    .clk(clk), .rst(rst), .en(o_en), .mode(o_mode),
    .pwm_out(o_pwm), .period_done(o_pd), .level(o_level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Clock index k after the enabling edge: 1H/2L, 2H/4L, 3H/6L, then the n=4 high phase.
  localparam logic [0:21] PWM_PAT = 22'b1001100001110000001111;
  localparam logic [0:21] PD_PAT  = 22'b0001000001000000001000;

  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lvl_at(input int k);
    return (k < 3) ? 1 : (k < 9) ? 2 : (k < 18) ? 3 : 4;
  endfunction

  task automatic wait_tpd(input int c, output bit ok);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!t_pd[c] && k < 64);
    ok = t_pd[c];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok0, ok1;
    logic [1:0] e0, e1;
    rst = 1'b1;
    d_en = '0; d_mode = '0; t_en = '0; t_mode = '0; o_en = 1'b0; o_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwm",   32'(d_pwm),   32'h0);
    check("reset_pd",    32'(d_pd),    32'h0);
    check("reset_level", 32'(d_level), 32'h1111);

    // Smoke + second channel offset by 5 clocks
    @(negedge clk);
    rst = 1'b0;
    d_en[0] = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i == 5) d_en[1] = 1'b1;
      step();
      if (i < 22) begin
        check("ch0_pwm",   32'(d_pwm[0]),      32'(PWM_PAT[i]));
        check("ch0_pd",    32'(d_pd[0]),       32'(PD_PAT[i]));
        check("ch0_level", 32'(d_level[3:0]),  32'(lvl_at(i)));
      end
      if (i >= 5) begin
        check("ch1_pwm",   32'(d_pwm[1]),      32'(PWM_PAT[i-5]));
        check("ch1_pd",    32'(d_pd[1]),       32'(PD_PAT[i-5]));
        check("ch1_level", 32'(d_level[7:4]),  32'(lvl_at(i-5)));
      end
    end

    // Drop en[0] mid-LOW; channel 1 is on its n=4 period boundary
    d_en[0] = 1'b0;
    step();
    check("drop_pwm0",   32'(d_pwm[0]),     32'h0);
    check("drop_level0", 32'(d_level[3:0]), 32'h1);
    check("drop_pd0",    32'(d_pd[0]),      32'h0);
    check("drop_pwm1",   32'(d_pwm[1]),     32'h1);
    check("drop_pd1",    32'(d_pd[1]),      32'h1);
    check("drop_level1", 32'(d_level[7:4]), 32'h4);

    // Asynchronous reset mid-HIGH
    step();
    check("pre_rst_pwm1", 32'(d_pwm[1]), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_pwm",   32'(d_pwm),   32'h0);
    check("rst_pd",    32'(d_pd),    32'h0);
    check("rst_level", 32'(d_level), 32'h1111);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("restart_pwm1", 32'(d_pwm[1]), 32'(PWM_PAT[i]));
      check("restart_pd1",  32'(d_pd[1]),  32'(PD_PAT[i]));
    end
    d_en = '0;

    // Triangle on channel 0, sawtooth on channel 1, N_MAX=3
    t_mode = 2'b10;
    t_en   = 2'b11;
    step();
    check("tri_start_level", 32'(t_level), 32'h5);
    check("tri_start_pwm",   32'(t_pwm),   32'h3);
    fork
      begin
        logic [1:0] seq0[$];
        seq0 = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3};
        while (seq0.size() > 0) begin
          e0 = seq0.pop_front();
          wait_tpd(0, ok0);
          check("tri_pd_seen", 32'(ok0), 32'h1);
          check("tri_level",   32'(t_level[1:0]), 32'(e0));
        end
      end
      begin
        logic [1:0] seq1[$];
        seq1 = '{2'd2, 2'd3, 2'd1, 2'd2};
        while (seq1.size() > 0) begin
          e1 = seq1.pop_front();
          wait_tpd(1, ok1);
          check("saw_pd_seen", 32'(ok1), 32'h1);
          check("saw_level",   32'(t_level[3:2]), 32'(e1));
        end
      end
    join

    // Mode changes mid-HIGH take effect only at the next update
    t_en = 2'b00;
    step();
    check("tri_off_level", 32'(t_level), 32'h5);
    check("tri_off_pwm",   32'(t_pwm),   32'h0);
    t_mode[1] = 1'b1;
    t_en[1]   = 1'b1;
    exp_q = '{2'd2, 2'd3};
    while (exp_q.size() > 0) begin
      e1 = exp_q.pop_front();
      wait_tpd(1, ok1);
      check("mode_pd_seen", 32'(ok1), 32'h1);
      check("mode_level",   32'(t_level[3:2]), 32'(e1));
    end
    t_mode[1] = 1'b0;
    step();
    check("mode_hold_level", 32'(t_level[3:2]), 32'h3);
    check("mode_hold_pwm",   32'(t_pwm[1]),     32'h1);
    wait_tpd(1, ok1);
    check("saw_to_tri_pd",    32'(ok1), 32'h1);
    check("saw_to_tri_level", 32'(t_level[3:2]), 32'h2);
    t_mode[1] = 1'b1;
    wait_tpd(1, ok1);
    check("tri_to_saw_pd",    32'(ok1), 32'h1);
    check("tri_to_saw_level", 32'(t_level[3:2]), 32'h3);
    t_en = '0;

    // N_MAX=1: 1H/1L periods, n pinned at 1
    o_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("one_pwm",   32'(o_pwm),   32'((i % 2) == 0));
      check("one_pd",    32'(o_pd),    32'(i == 2 || i == 4));
      check("one_level", 32'(o_level), 32'h1);
    end
    o_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
